decode_issue_stage: RTL
=======================

Name: decode_issue_stage

Overview:
Parametrised successor to the decode/operand-fetch stage of the 3-stage pipeline. It accepts instructions from fetch under a valid/ready handshake and holds one instruction in a decode register. It reads operands from the register file, forwards writeback data, and stalls on scoreboard hazards. Decoded operations issue into an output pipeline register toward Execute, and each issue claims its destination in the scoreboard.

Parameters:
DATA_W, 16, operand/register data width
REG_AW, 4, register index width; instruction width is INSTR_W = 4 + 3*REG_AW, memory-address width is 2*REG_AW
CNT_W, 8, width of the saturating stall counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  fetch offers an instruction
in_ready  out  1  stage can accept an instruction this cycle
instr  in  INSTR_W  {opcode[4], f2, f1, f0}, fields REG_AW each, f2 most significant
srcReg1  out  REG_AW  register-file read index 1 (combinational)
srcReg2  out  REG_AW  register-file read index 2 (combinational)
srcRegVal1  in  DATA_W  register-file read data 1, same cycle
srcRegVal2  in  DATA_W  register-file read data 2, same cycle
inuse1  in  1  scoreboard busy bit for srcReg1
inuse2  in  1  scoreboard busy bit for srcReg2
inuseDest  in  1  scoreboard busy bit for nextDestReg
wb_en  in  1  writeback this cycle
wb_reg  in  REG_AW  writeback index
wb_data  in  DATA_W  writeback value
nextDestReg  out  REG_AW  destination index of the held instruction (combinational)
claim_en  out  1  one-cycle pulse on issue of a writing instruction
flush  in  1  synchronous kill of held and output instructions
out_valid  out  1  output register holds a decoded operation
out_ready  in  1  Execute accepts the output
opcode  out  4  registered opcode
destReg  out  REG_AW  registered destination
srcVal1  out  DATA_W  registered operand 1
srcVal2  out  DATA_W  registered operand 2
memAddr  out  2*REG_AW  registered address {f2,f1}
stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (async, rst=1): hold_valid=0, out_valid=0; opcode, destReg, srcVal1/2, memAddr, stall_cnt = 0. Combinational outputs srcReg1/2, nextDestReg and claim_en are 0 while nothing is held.
- Field decode of the held instruction, by class:
  - NOP (0000): no sources, no dest.
  - LOAD (1110): dest=f0, addr={f2,f1}, no sources.
  - STORE (1111): src1=f0, addr={f2,f1}, no dest.
  - Other: dest=f2, src1=f1, src2=f0, memAddr=0.
  - An unused srcReg index drives 0, and its operand is not hazard-checked.
- Operand ready: a used source is ready when its inuse bit is 0, or when wb_en=1 and wb_reg matches it.
- Operand value: wb_data takes priority over srcRegVal when wb_en=1 and wb_reg matches. Unused operands register 0.
- hazard = hold_valid and (a used source is not ready, or the instruction writes and inuseDest=1 with no matching wb_en).
- issue = hold_valid and !hazard and (!out_valid or out_ready).
- in_ready = !hold_valid or issue (combinational; one-cycle decode when there is no stall).
- Accept: when in_valid and in_ready, instr is captured into the hold register, hold_valid=1. Back-to-back throughput is 1 instruction/cycle.
- On issue:
  - The output register loads opcode, destReg, srcVal1/2 and memAddr; out_valid=1.
  - claim_en=1 for the same cycle unless the opcode is NOP or STORE; nextDestReg carries the destination.
- When out_valid and out_ready and there is no issue, out_valid goes to 0; the output fields hold their values.
- Hazard counting: stall_cnt increments on every cycle where hazard=1 and saturates at all-ones. It is cleared only by reset.
- Flush has priority over everything:
  - The next edge clears hold_valid and out_valid.
  - claim_en is forced to 0 and in_ready is forced to 0 that cycle.
  - Output fields are not cleared.
- Reset mid-stall drops the held instruction with no claim.
- A wb_en whose wb_reg matches no used source has no effect.
- Simultaneous writeback and issue: the forwarded value is the one registered.

Test Plan:
1. Reset, then instr=0010_0011_0011_0001 with in_valid=1, srcRegVal1=40, srcRegVal2=50, inuse=0 -> 2 edges later out_valid=1, opcode=0010, destReg=3, srcVal1=40, srcVal2=50; claim_en pulsed once with nextDestReg=3.
2. LOAD 1110_1100_1110_1100 -> destReg=12, memAddr=0xCE, srcVal1=srcVal2=0. STORE 1111_0111_1110_1111 with srcRegVal1=80 -> srcVal1=80, memAddr=0x7E, claim_en never 1.
3. ADD with src1=2 and inuse1=1 held for 3 cycles -> in_ready=0, out_valid stays 0, stall_cnt=3. Then wb_en=1, wb_reg=2, wb_data=99 -> issues the next cycle with srcVal1=99.
4. out_ready=0 with out_valid=1 while a new instruction is held -> no issue, in_ready=0, outputs stable. out_ready=1 -> issue on the next edge, 1 instruction/cycle thereafter.
5. flush=1 with hold_valid=1 and out_valid=1 -> next cycle both 0, no claim_en. Async rst mid-stall -> all outputs immediately 0, stall_cnt=0.
6. Force 300 hazard cycles with CNT_W=8 -> stall_cnt saturates at 255.

Source files
------------

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: holds one fetched instruction, fetches and forwards operands,
// stalls on scoreboard hazards and issues into an output register toward Execute.
module decode_issue_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4+3*REG_AW-1:0]   instr,
  output logic [REG_AW-1:0]       srcReg1,
  output logic [REG_AW-1:0]       srcReg2,
  input  logic [DATA_W-1:0]       srcRegVal1,
  input  logic [DATA_W-1:0]       srcRegVal2,
  input  logic                    inuse1,
  input  logic                    inuse2,
  input  logic                    inuseDest,
  input  logic                    wb_en,
  input  logic [REG_AW-1:0]       wb_reg,
  input  logic [DATA_W-1:0]       wb_data,
  output logic [REG_AW-1:0]       nextDestReg,
  output logic                    claim_en,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              opcode,
  output logic [REG_AW-1:0]       destReg,
  output logic [DATA_W-1:0]       srcVal1,
  output logic [DATA_W-1:0]       srcVal2,
  output logic [2*REG_AW-1:0]     memAddr,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int INSTR_W = 4 + 3*REG_AW;
  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_LOAD  = 4'b1110;
  localparam logic [3:0] OP_STORE = 4'b1111;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] pick_operand(input logic used, input logic fwd,
                                                     input logic [DATA_W-1:0] rf_val,
                                                     input logic [DATA_W-1:0] wb_val);
    if (!used)
      return '0;
    else if (fwd)
      return wb_val;
    else
      return rf_val;
  endfunction

  logic                 hold_valid_q, hold_valid_d;
  logic [INSTR_W-1:0]   hold_instr_q;
  logic                 out_valid_q, out_valid_d;
  logic [3:0]           opcode_q, opcode_d;
  logic [REG_AW-1:0]    dest_q, dest_d;
  logic [DATA_W-1:0]    val1_q, val1_d;
  logic [DATA_W-1:0]    val2_q, val2_d;
  logic [2*REG_AW-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

  logic [3:0]           h_opc;
  logic [REG_AW-1:0]    h_f2, h_f1, h_f0;
  logic                 is_nop, is_load, is_store;
  logic                 uses_src1, uses_src2, writes_dest;
  logic [REG_AW-1:0]    src1_idx, src2_idx, dest_idx;
  logic [2*REG_AW-1:0]  mem_addr;
  logic                 wb_hit1, wb_hit2, wb_hit_dest;
  logic                 src1_ready, src2_ready, dest_free;
  logic                 hazard, out_free, issue, accept;

  assign {h_opc, h_f2, h_f1, h_f0} = hold_instr_q;

  assign is_nop   = (h_opc == OP_NOP);
  assign is_load  = (h_opc == OP_LOAD);
  assign is_store = (h_opc == OP_STORE);

  // Every use bit is qualified by hold_valid so all indices read 0 when empty.
  assign uses_src1   = hold_valid_q & ~is_nop & ~is_load;
  assign uses_src2   = hold_valid_q & ~is_nop & ~is_load & ~is_store;
  assign writes_dest = hold_valid_q & ~is_nop & ~is_store;

  assign src1_idx = uses_src1 ? (is_store ? h_f0 : h_f1) : '0;
  assign src2_idx = uses_src2 ? h_f0 : '0;
  assign dest_idx = writes_dest ? (is_load ? h_f0 : h_f2) : '0;
  assign mem_addr = (hold_valid_q & (is_load | is_store)) ? {h_f2, h_f1} : '0;

  assign wb_hit1     = uses_src1   & wb_en & (wb_reg == src1_idx);
  assign wb_hit2     = uses_src2   & wb_en & (wb_reg == src2_idx);
  assign wb_hit_dest = writes_dest & wb_en & (wb_reg == dest_idx);

  assign src1_ready = ~uses_src1   | ~inuse1    | wb_hit1;
  assign src2_ready = ~uses_src2   | ~inuse2    | wb_hit2;
  assign dest_free  = ~writes_dest | ~inuseDest | wb_hit_dest;

  assign hazard   = hold_valid_q & ~(src1_ready & src2_ready & dest_free);
  assign out_free = ~out_valid_q | out_ready;
  // Flush suppresses issue so nothing is claimed or loaded on a killed cycle.
  assign issue    = hold_valid_q & ~hazard & out_free & ~flush;
  assign in_ready = ~flush & (~hold_valid_q | issue);
  assign accept   = in_valid & in_ready;

  assign srcReg1     = src1_idx;
  assign srcReg2     = src2_idx;
  assign nextDestReg = dest_idx;
  assign claim_en    = issue & writes_dest;

  always_comb begin
    hold_valid_d = hold_valid_q;
    out_valid_d  = out_valid_q;
    opcode_d     = opcode_q;
    dest_d       = dest_q;
    val1_d       = val1_q;
    val2_d       = val2_q;
    addr_d       = addr_q;
    stall_cnt_d  = hazard ? sat_inc(stall_cnt_q) : stall_cnt_q;

    if (flush) begin
      hold_valid_d = 1'b0;
      out_valid_d  = 1'b0;
    end else begin
      if (accept)
        hold_valid_d = 1'b1;
      else if (issue)
        hold_valid_d = 1'b0;

      if (issue) begin
        out_valid_d = 1'b1;
        opcode_d    = h_opc;
        dest_d      = dest_idx;
        val1_d      = pick_operand(uses_src1, wb_hit1, srcRegVal1, wb_data);
        val2_d      = pick_operand(uses_src2, wb_hit2, srcRegVal2, wb_data);
        addr_d      = mem_addr;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Decode -> output register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      opcode_q     <= '0;
      dest_q       <= '0;
      val1_q       <= '0;
      val2_q       <= '0;
      addr_q       <= '0;
      stall_cnt_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      out_valid_q  <= out_valid_d;
      opcode_q     <= opcode_d;
      dest_q       <= dest_d;
      val1_q       <= val1_d;
      val2_q       <= val2_d;
      addr_q       <= addr_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Fetch -> decode register boundary; contents are qualified by hold_valid_q.
  always_ff @(posedge clk) begin
    if (accept)
      hold_instr_q <= instr;
  end

  assign out_valid = out_valid_q;
  assign opcode    = opcode_q;
  assign destReg   = dest_q;
  assign srcVal1   = val1_q;
  assign srcVal2   = val2_q;
  assign memAddr   = addr_q;
  assign stall_cnt = stall_cnt_q;

endmodule
